// File: rtl/shift_unit_pkg.sv
// Shared definitions for the multi-cycle shifter: mode encodings and FSM states.
package shift_unit_pkg;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP bits.
// Optional feature macro: SHIFT_UNIT_ROTATE_EN (adds rotate-right for mode 11).
// Ports:
//   i_acc   : current accumulator value
//   i_s     : shift amount for this step (0..STEP)
//   i_mode  : SLL / SRL / SRA / ROR
//   o_acc_c : accumulator after the step (combinational)
module shift_step
   import shift_unit_pkg::*;
#(
   parameter int unsigned N    = 32,
   parameter int unsigned STEP = 4,
   parameter int unsigned SW   = $clog2(STEP + 1)
) (
   input  logic [N-1:0]  i_acc,
   input  logic [SW-1:0] i_s,
   input  logic [1:0]    i_mode,
   output logic [N-1:0]  o_acc_c
);

   // Per-mode fill: zeros for logical shifts, sign copies for SRA, wrapped bits for ROR
   always_comb begin
      o_acc_c = i_acc;
      case (i_mode)
         MODE_SLL: o_acc_c = i_acc << i_s;
         MODE_SRL: o_acc_c = i_acc >> i_s;
         MODE_SRA: o_acc_c = $unsigned($signed(i_acc) >>> i_s);
`ifdef SHIFT_UNIT_ROTATE_EN
         // Low half of the doubled word shifted right is the rotated value
         MODE_ROR: o_acc_c = N'({i_acc, i_acc} >> i_s);
`endif
         default:  o_acc_c = i_acc;
      endcase
   end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle variable shifter (SLL/SRL/SRA, optional ROR) with start/done handshake.
// Shifts at most STEP bits per cycle; done pulses for one cycle when dout is valid.
// Optional feature macro: SHIFT_UNIT_ROTATE_EN (mode 11 rotates right; otherwise
// mode 11 is invalid and passes din through with latency 1).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request, accepted in IDLE or DONE
//   mode       : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   din, shamt : operand and shift amount, sampled at accept
//   busy       : high while in SHIFT
//   done       : one-cycle pulse with valid dout
//   dout       : result, held until the next DONE
module shift_unit_seq
   import shift_unit_pkg::*;
#(
   parameter int unsigned N       = 32,
   parameter int unsigned SHAMT_W = $clog2(N),
   parameter int unsigned STEP    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [N-1:0]       din,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [N-1:0]       dout
);

   localparam int unsigned SW = $clog2(STEP + 1);

   state_t             r_state;
   state_t             w_next;
   logic [N-1:0]       r_acc;
   logic [SHAMT_W-1:0] r_rem;
   logic [1:0]         r_mode;
   logic               r_busy;
   logic               r_done;
   logic [N-1:0]       r_dout;

   logic               w_accept;
   logic               w_mode_ok;
   logic [SW-1:0]      w_s;
   logic [SHAMT_W-1:0] w_rem_next;
   logic [N-1:0]       w_acc_step;
   logic [N-1:0]       w_dout_next;

`ifdef SHIFT_UNIT_ROTATE_EN
   assign w_mode_ok = 1'b1;
`else
   assign w_mode_ok = (mode != MODE_ROR);
`endif

   // Step size is min(rem, STEP)
   always_comb begin
      if (32'(r_rem) > 32'(STEP)) w_s = SW'(STEP);
      else                        w_s = SW'(r_rem);
   end

   assign w_rem_next = r_rem - SHAMT_W'(w_s);

   shift_step #(
      .N    (N),
      .STEP (STEP),
      .SW   (SW)
   ) u_step (
      .i_acc   (r_acc),
      .i_s     (w_s),
      .i_mode  (r_mode),
      .o_acc_c (w_acc_step)
   );

   // Next-state logic; accept only from IDLE or DONE
   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         IDLE:    if (start) w_accept = 1'b1;
         SHIFT:   if (w_rem_next == '0) w_next = DONE;
         DONE:    if (start) w_accept = 1'b1;
                  else       w_next   = IDLE;
         default: w_next = IDLE;
      endcase
      if (w_accept) begin
         if ((shamt != '0) && w_mode_ok) w_next = SHIFT;
         else                            w_next = DONE;
      end
   end

   // Zero-shift and invalid-mode accepts go straight to DONE with din as result
   assign w_dout_next = w_accept ? din : w_acc_step;

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_rem   <= '0;
         r_mode  <= MODE_SLL;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == SHIFT);
         r_done  <= (w_next == DONE);
         if (w_accept) begin
            r_acc  <= din;
            r_rem  <= shamt;
            r_mode <= mode;
         end else if (r_state == SHIFT) begin
            r_acc <= w_acc_step;
            r_rem <= w_rem_next;
         end
         if (w_next == DONE) r_dout <= w_dout_next;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign dout = r_dout;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq (N=32, STEP=4): stimulus pushes expected
// result/latency/busy-count, a negedge monitor pops and checks on each done.
// Honours SHIFT_UNIT_ROTATE_EN for the mode-11 expectation.
module tb_shift_unit_seq;
   import shift_unit_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mode  = 2'b00;
   logic [31:0] din   = '0;
   logic [4:0]  shamt = '0;
   logic        busy;
   logic        done;
   logic [31:0] dout;

   shift_unit_seq #(.N(32), .SHAMT_W(5), .STEP(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (mode),
      .din   (din),
      .shamt (shamt),
      .busy  (busy),
      .done  (done),
      .dout  (dout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] dout;
      int          lat;
      int          busy_n;
      int          acc_cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   busy_cnt = 0;
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
      end
   endtask

   // Monitor: counts busy cycles and checks every done pulse against the queue
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: dout=0x%08h with no request outstanding", dout);
            end else begin
               mon_e = sb.pop_front();
               chk({mon_e.name, "_dout"}, dout, mon_e.dout);
               chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc_cyc + 1), 32'(mon_e.lat));
               chk({mon_e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(mon_e.busy_n));
            end
            busy_cnt = 0;
         end
      end
   end

   // Drive one request for one edge and record the expected response
   task automatic issue(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] e_dout, input int e_lat, input int e_busy,
                        input string nm);
      exp_t e;
      mode = m; din = d; shamt = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e.dout = e_dout; e.lat = e_lat; e.busy_n = e_busy; e.acc_cyc = cyc; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input string nm);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: %0d results outstanding, required 0", nm, sb.size());
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      exp_t e;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_dout", dout, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(MODE_SLL, 32'h0000_0001, 5'd2,  32'h0000_0004, 2, 1, "sll_1_by_2");
      wait_drain("sll_1_by_2");
      issue(MODE_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9, 8, "sra_by_31");
      wait_drain("sra_by_31");
      issue(MODE_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 9, 8, "srl_by_31");
      wait_drain("srl_by_31");
      issue(MODE_SRL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1, 0, "srl_by_0");
      wait_drain("srl_by_0");
      issue(MODE_SRA, 32'h8765_4321, 5'd5,  32'hFC3B_2A19, 3, 2, "sra_neg_by_5");
      wait_drain("sra_neg_by_5");

      // Back-to-back with ignored starts during SHIFT
      mode = MODE_SRL; din = 32'hF000_0000; shamt = 5'd4; start = 1'b1;
      @(posedge clk); #1;
      e.dout = 32'h0F00_0000; e.lat = 2; e.busy_n = 1; e.acc_cyc = cyc; e.name = "b2b_first";
      sb.push_back(e);
      mode = MODE_SLL; din = 32'hFFFF_FFFF; shamt = 5'd3; start = 1'b1;
      @(posedge clk); #1;
      mode = MODE_SLL; din = 32'h0000_0001; shamt = 5'd8; start = 1'b1;
      @(posedge clk); #1;
      e.dout = 32'h0000_0100; e.lat = 3; e.busy_n = 2; e.acc_cyc = cyc; e.name = "b2b_second";
      sb.push_back(e);
      mode = MODE_SRA; din = 32'hAAAA_AAAA; shamt = 5'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_drain("b2b");

`ifdef SHIFT_UNIT_ROTATE_EN
      issue(MODE_ROR, 32'h1234_5678, 5'd8, 32'h7812_3456, 3, 2, "ror_by_8");
`else
      issue(MODE_ROR, 32'h1234_5678, 5'd8, 32'h1234_5678, 1, 0, "mode11_invalid");
`endif
      wait_drain("mode11");

      // Reset mid-SHIFT abandons the operation without a done pulse
      mode = MODE_SRA; din = 32'h8000_0000; shamt = 5'd20; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_done", 32'(done), 32'd0);
      chk("midreset_dout", dout, 32'h0);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;

      // Reset wins over a simultaneous start
      rst_n = 1'b0; mode = MODE_SLL; din = 32'h0000_0003; shamt = 5'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rst_n = 1'b1;
      chk("reset_vs_start_done", 32'(done), 32'd0);
      repeat (4) @(posedge clk);
      #1;

      chk("queue_empty_at_end", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
